io_serial_port: RTL and testbench



---
 rtl/io_serial_pkg.sv | 34 +++
 rtl/serial_tx_core.sv | 109 ++++++++++
 rtl/io_serial_port.sv | 223 ++++++++++++++++++++++
 tb/tb_io_serial_port.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_serial_pkg.sv
// rtl/io_serial_pkg.sv - shared register offsets, RSR bit positions and serial FSM states
package io_serial_pkg;

    localparam logic [1:0] RSR_OFS = 2'd0;
    localparam logic [1:0] RBR_OFS = 2'd1;
    localparam logic [1:0] TBR_OFS = 2'd2;

    localparam int RSR_FI = 0;
    localparam int RSR_OE = 1;
    localparam int RSR_FE = 2;
    localparam int RSR_PE = 3;
    localparam int RSR_TE = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ser_state_e;

    function automatic logic [7:0] pack_rsr(input logic fi, input logic oe, input logic fe,
                                            input logic pe, input logic te);
        logic [7:0] r;
        r         = 8'h00;
        r[RSR_FI] = fi;
        r[RSR_OE] = oe;
        r[RSR_FE] = fe;
        r[RSR_PE] = pe;
        r[RSR_TE] = te;
        return r;
    endfunction

endpackage

// File: rtl/serial_tx_core.sv
// rtl/serial_tx_core.sv - serial frame transmitter (start, 8 data LSB first, [parity], stop)
// Ports: clock, reset (async, active-high); load/byte_in accept a byte while idle;
//        busy is high for the whole frame; txd is the registered serial line (idle high).
// Optional: IO_SERIAL_PARITY_EN inserts an even-parity bit before the stop bit.
module serial_tx_core
    import io_serial_pkg::*;
#(
    parameter int BIT_TICKS = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       busy,
    output logic       txd
);

    localparam logic [15:0] LAST = 16'(BIT_TICKS - 1);

    ser_state_e  state, state_n;
    logic [15:0] tick, tick_n;
    logic [2:0]  bit_idx, bit_n;
    logic [7:0]  shift, shift_n;
    logic        txd_n;
`ifdef IO_SERIAL_PARITY_EN
    logic        par;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            tick    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
`ifdef IO_SERIAL_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            tick    <= tick_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            txd     <= txd_n;
`ifdef IO_SERIAL_PARITY_EN
            if (state == ST_IDLE && load) par <= ^byte_in;
`endif
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick + 16'd1;
        bit_n   = bit_idx;
        shift_n = shift;
        case (state)
            ST_IDLE: begin
                tick_n = '0;
                if (load) begin
                    state_n = ST_START;
                    shift_n = byte_in;
                end
            end
            ST_START: if (tick == LAST) begin
                tick_n  = '0;
                bit_n   = '0;
                state_n = ST_DATA;
            end
            ST_DATA: if (tick == LAST) begin
                tick_n  = '0;
                shift_n = {1'b0, shift[7:1]};
                if (bit_idx == 3'd7) begin
`ifdef IO_SERIAL_PARITY_EN
                    state_n = ST_PARITY;
`else
                    state_n = ST_STOP;
`endif
                end else begin
                    bit_n = bit_idx + 3'd1;
                end
            end
`ifdef IO_SERIAL_PARITY_EN
            ST_PARITY: if (tick == LAST) begin
                tick_n  = '0;
                state_n = ST_STOP;
            end
`endif
            ST_STOP: if (tick == LAST) begin
                tick_n  = '0;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // txd is registered from the next state so the line changes on the same
        // edge the FSM moves, with no combinational decode on the pin.
        case (state_n)
            ST_START:  txd_n = 1'b0;
            ST_DATA:   txd_n = shift_n[0];
`ifdef IO_SERIAL_PARITY_EN
            ST_PARITY: txd_n = par;
`endif
            default:   txd_n = 1'b1;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: rtl/io_serial_port.sv
// rtl/io_serial_port.sv - bus-responder serial port with RSR/RBR/TBR registers
// Ports: clock, reset (async, active-high); addr/data/ior_/iow_ bus responder
//        (data driven only on a matching read); rxd serial in, txd serial out.
// Optional: IO_SERIAL_PARITY_EN adds even parity on both directions and RSR bit3 PE.
module io_serial_port
    import io_serial_pkg::*;
#(
    parameter logic [15:0] BASE      = 16'h0100,
    parameter int          BIT_TICKS = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr,
    inout  wire  [7:0]  data,
    input  logic        ior_,
    input  logic        iow_,
    input  logic        rxd,
    output logic        txd
);

    localparam logic [15:0] LAST = 16'(BIT_TICKS - 1);
    localparam logic [15:0] HALF = 16'(BIT_TICKS / 2 - 1);

    logic [15:0] ofs_full;
    logic        in_range, sel_rsr, sel_rbr;
    logic        ior_q, ior_qq, iow_q, iow_qq;
    logic        rd_rbr, wr_hit;
    logic [1:0]  wr_ofs;
    logic [7:0]  wr_hold;
    logic        rd_clear, wr_commit, wr_tbr, wr_rsr;
    logic        fi, oe, fe, pe, te;
    logic [7:0]  rbr, tbr, rsr;
    logic        tx_busy, tx_load;
    logic [1:0]  rxd_sync;
    logic        rxd_s;

    ser_state_e  rx_state, rx_state_n;
    logic [15:0] rx_tick, rx_tick_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_done, rx_stop_ok;
`ifdef IO_SERIAL_PARITY_EN
    logic        rx_par_bad, rx_par_bad_n;
`else
    assign pe = 1'b0;
`endif

    // ---------------- bus decode ----------------
    assign ofs_full = addr - BASE;
    assign in_range = (ofs_full < 16'd3);
    assign sel_rsr  = (addr == BASE);
    assign sel_rbr  = (addr == BASE + 16'd1);
    assign rsr      = pack_rsr(fi, oe, fe, pe, te);
    assign data     = (!ior_ && (sel_rsr || sel_rbr)) ? (sel_rsr ? rsr : rbr) : 8'bz;

    // Strobe edges are taken from the registered copies, so the decode latched
    // while the strobe was low is what commits, even if addr moves at the rise.
    assign rd_clear  = !ior_qq && ior_q && rd_rbr;
    assign wr_commit = !iow_qq && iow_q && wr_hit;
    assign wr_tbr    = wr_commit && (wr_ofs == TBR_OFS);
    assign wr_rsr    = wr_commit && (wr_ofs == RSR_OFS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ior_q    <= 1'b1;
            ior_qq   <= 1'b1;
            iow_q    <= 1'b1;
            iow_qq   <= 1'b1;
            rd_rbr   <= 1'b0;
            wr_hit   <= 1'b0;
            wr_ofs   <= RSR_OFS;
            wr_hold  <= 8'h00;
            rxd_sync <= 2'b11;
        end else begin
            ior_q    <= ior_;
            ior_qq   <= ior_q;
            iow_q    <= iow_;
            iow_qq   <= iow_q;
            rxd_sync <= {rxd_sync[0], rxd};
            if (!ior_) rd_rbr <= sel_rbr;
            if (!iow_) begin
                wr_hit <= in_range;
                wr_ofs <= ofs_full[1:0];
                if (in_range) wr_hold <= data;
            end
        end
    end

    assign rxd_s = rxd_sync[1];

    // ---------------- receive FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state   <= ST_IDLE;
            rx_tick    <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
`ifdef IO_SERIAL_PARITY_EN
            rx_par_bad <= 1'b0;
`endif
        end else begin
            rx_state   <= rx_state_n;
            rx_tick    <= rx_tick_n;
            rx_bit     <= rx_bit_n;
            rx_shift   <= rx_shift_n;
`ifdef IO_SERIAL_PARITY_EN
            rx_par_bad <= rx_par_bad_n;
`endif
        end
    end

    always_comb begin
        rx_state_n   = rx_state;
        rx_tick_n    = rx_tick + 16'd1;
        rx_bit_n     = rx_bit;
        rx_shift_n   = rx_shift;
        rx_done      = 1'b0;
        rx_stop_ok   = 1'b0;
`ifdef IO_SERIAL_PARITY_EN
        rx_par_bad_n = rx_par_bad;
`endif
        case (rx_state)
            ST_IDLE: begin
                rx_tick_n = '0;
                if (!rxd_s) rx_state_n = ST_START;
            end
            // Half-bit re-sample: a low pulse shorter than this is a glitch.
            ST_START: if (rx_tick == HALF) begin
                rx_tick_n  = '0;
                rx_bit_n   = '0;
                rx_state_n = rxd_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (rx_tick == LAST) begin
                rx_tick_n  = '0;
                rx_shift_n = {rxd_s, rx_shift[7:1]};
                if (rx_bit == 3'd7) begin
`ifdef IO_SERIAL_PARITY_EN
                    rx_state_n = ST_PARITY;
`else
                    rx_state_n = ST_STOP;
`endif
                end else begin
                    rx_bit_n = rx_bit + 3'd1;
                end
            end
`ifdef IO_SERIAL_PARITY_EN
            ST_PARITY: if (rx_tick == LAST) begin
                rx_tick_n    = '0;
                rx_par_bad_n = rxd_s ^ (^rx_shift);
                rx_state_n   = ST_STOP;
            end
`endif
            ST_STOP: if (rx_tick == LAST) begin
                rx_tick_n  = '0;
                rx_done    = 1'b1;
                rx_stop_ok = rxd_s;
                rx_state_n = ST_IDLE;
            end
            default: rx_state_n = ST_IDLE;
        endcase
    end

    // ---------------- registers and flags ----------------
    assign tx_load = !te && !tx_busy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fi  <= 1'b0;
            oe  <= 1'b0;
            fe  <= 1'b0;
            te  <= 1'b1;
            rbr <= 8'h00;
            tbr <= 8'h00;
`ifdef IO_SERIAL_PARITY_EN
            pe  <= 1'b0;
`endif
        end else begin
            // A TBR write in the load cycle wins: the old byte goes out and the
            // new one stays pending.
            if (tx_load) te <= 1'b1;
            if (wr_tbr) begin
                tbr <= wr_hold;
                te  <= 1'b0;
            end
            if (wr_rsr) begin
                oe <= 1'b0;
                fe <= 1'b0;
`ifdef IO_SERIAL_PARITY_EN
                pe <= 1'b0;
`endif
            end
            if (rd_clear) fi <= 1'b0;
            // A read-clear in the commit cycle frees RBR for the new byte.
            if (rx_done) begin
                if (rx_stop_ok) begin
                    if (!fi || rd_clear) begin
                        rbr <= rx_shift;
                        fi  <= 1'b1;
                    end else begin
                        oe <= 1'b1;
                    end
`ifdef IO_SERIAL_PARITY_EN
                    if (rx_par_bad) pe <= 1'b1;
`endif
                end else begin
                    fe <= 1'b1;
                end
            end
        end
    end

    serial_tx_core #(
        .BIT_TICKS(BIT_TICKS)
    ) u_tx (
        .clock  (clock),
        .reset  (reset),
        .load   (tx_load),
        .byte_in(tbr),
        .busy   (tx_busy),
        .txd    (txd)
    );

endmodule

// File: tb/tb_io_serial_port.sv
// tb/tb_io_serial_port.sv - randomized self-checking bench for io_serial_port
module tb_io_serial_port;

    localparam int          BT   = 16;
    localparam logic [15:0] BASE = 16'h0100;
`ifdef IO_SERIAL_PARITY_EN
    localparam int          NB   = 11;
`else
    localparam int          NB   = 10;
`endif
    // Pullups make an undriven bus read back as FF.
    localparam logic [7:0]  HIZ  = 8'hFF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr  = 16'h0000;
    logic        ior_  = 1'b1;
    logic        iow_  = 1'b1;
    logic        rxd   = 1'b1;
    wire         txd;
    wire  [7:0]  data;
    logic [7:0]  drv_val = 8'h00;
    logic        drv_en  = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model of the receive-side flags and buffer.
    logic       m_fi = 1'b0, m_oe = 1'b0, m_fe = 1'b0;
    logic [7:0] m_rbr = 8'h00;

    assign data = drv_en ? drv_val : 8'bz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (data[g]);
    end

    always #5 clock = ~clock;

    io_serial_port #(.BASE(BASE), .BIT_TICKS(BT)) dut (
        .clock(clock),
        .reset(reset),
        .addr (addr),
        .data (data),
        .ior_ (ior_),
        .iow_ (iow_),
        .rxd  (rxd),
        .txd  (txd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    function automatic logic [7:0] exp_rsr(input logic te);
        return {2'b00, te, 2'b00, m_fe, m_oe, m_fi};
    endfunction

    // Line levels in time order: start, data LSB first, [even parity], stop.
    function automatic logic [10:0] tx_frame(input logic [7:0] b);
        logic [10:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[i + 1] = b[i];
`ifdef IO_SERIAL_PARITY_EN
        f[9] = ^b;
`endif
        f[NB - 1] = 1'b1;
        return f;
    endfunction

    task automatic bus_write(input logic [15:0] a, input logic [7:0] v);
        @(negedge clock);
        addr = a; drv_val = v; drv_en = 1'b1; iow_ = 1'b0;
        repeat (2) @(negedge clock);
        iow_ = 1'b1; drv_en = 1'b0; addr = 16'($urandom);
        repeat (3) @(negedge clock);
        if (a == BASE) begin m_oe = 1'b0; m_fe = 1'b0; end
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] v);
        @(negedge clock);
        addr = a; ior_ = 1'b0;
        @(negedge clock);
        v = data;
        @(negedge clock);
        ior_ = 1'b1; addr = 16'($urandom);
        repeat (3) @(negedge clock);
        if (a == BASE + 16'd1) m_fi = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (BT) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BT) @(negedge clock);
        end
`ifdef IO_SERIAL_PARITY_EN
        rxd = ^b;
        repeat (BT) @(negedge clock);
`endif
        rxd = stop;
        repeat (BT) @(negedge clock);
        rxd = 1'b1;
        repeat (4) @(negedge clock);
        if (!stop) m_fe = 1'b1;
        else if (m_fi) m_oe = 1'b1;
        else begin m_rbr = b; m_fi = 1'b1; end
    endtask

    task automatic capture_tx(output logic [10:0] f);
        int n;
        f = '0;
        n = 0;
        while (txd !== 1'b0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (txd !== 1'b0) begin
            check("tx_start_timeout", 32'(txd), 32'd0);
        end else begin
            repeat (BT / 2) @(negedge clock);
            for (int i = 0; i < NB; i++) begin
                f[i] = txd;
                if (i < NB - 1) repeat (BT) @(negedge clock);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0]  v, b, x, y, z;
        logic [10:0] f1, f2;
        int          lows;

        // ---- reset ----
        repeat (3) @(negedge clock);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_bus_idle", 32'(data), 32'(HIZ));
        reset = 1'b0;
        bus_read(BASE, v);              check("rst_rsr", 32'(v), 32'h20);
        bus_read(BASE + 16'd3, v);      check("unmapped_p3", 32'(v), 32'(HIZ));
        bus_read(BASE - 16'd1, v);      check("unmapped_m1", 32'(v), 32'(HIZ));
        bus_read(BASE + 16'd2, v);      check("tbr_not_readable", 32'(v), 32'(HIZ));
        bus_read(BASE + 16'd1, v);      check("rst_rbr", 32'(v), 32'h00);

        // ---- transmit ----
        fork
            capture_tx(f1);
            bus_write(BASE + 16'd2, 8'hA5);
        join
        check("tx_a5", 32'(f1), 32'(tx_frame(8'hA5)));
        bus_read(BASE, v);              check("tx_a5_rsr", 32'(v), 32'h20);

        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            fork
                capture_tx(f1);
                bus_write(BASE + 16'd2, b);
            join
            check("tx_rand", 32'(f1), 32'(tx_frame(b)));
        end

        // Overwrite while busy: only the last written byte follows the frame.
        x = 8'($urandom); y = 8'($urandom); z = ~y;
        fork
            begin capture_tx(f1); capture_tx(f2); end
            begin
                bus_write(BASE + 16'd2, x);
                repeat (40) @(negedge clock);
                bus_write(BASE + 16'd2, y);
                bus_write(BASE + 16'd2, z);
                bus_read(BASE, v);
                check("tx_pending_rsr", 32'(v), 32'(exp_rsr(1'b0)));
            end
        join
        check("tx_first", 32'(f1), 32'(tx_frame(x)));
        check("tx_overwrite", 32'(f2), 32'(tx_frame(z)));
        bus_read(BASE, v);              check("tx_done_rsr", 32'(v), 32'(exp_rsr(1'b1)));

        // ---- receive ----
        send_rx(8'h3C, 1'b1);
        bus_read(BASE, v);              check("rx_3c_rsr", 32'(v), 32'(exp_rsr(1'b1)));
        bus_read(BASE + 16'd1, v);      check("rx_3c_rbr", 32'(v), 32'h3C);
        bus_read(BASE, v);              check("rx_3c_clr", 32'(v), 32'h20);

        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1);
            bus_read(BASE, v);          check("rx_rand_rsr", 32'(v), 32'(exp_rsr(1'b1)));
            bus_read(BASE + 16'd1, v);  check("rx_rand_rbr", 32'(v), 32'(m_rbr));
        end

        // Overrun keeps the first byte.
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        bus_read(BASE, v);              check("ovr_rsr", 32'(v), 32'h23);
        bus_write(BASE, 8'h00);
        bus_read(BASE, v);              check("ovr_clr_rsr", 32'(v), 32'(exp_rsr(1'b1)));
        bus_read(BASE + 16'd1, v);      check("ovr_rbr", 32'(v), 32'h11);
        bus_read(BASE, v);              check("ovr_final", 32'(v), 32'(exp_rsr(1'b1)));

        // Framing error, then a short low glitch.
        send_rx(8'h55, 1'b0);
        bus_read(BASE, v);              check("fe_rsr", 32'(v), 32'h24);
        rxd = 1'b0;
        repeat (4) @(negedge clock);
        rxd = 1'b1;
        repeat (40) @(negedge clock);
        bus_read(BASE, v);              check("glitch_rsr", 32'(v), 32'(exp_rsr(1'b1)));
        b = 8'($urandom);
        send_rx(b, 1'b1);
        bus_read(BASE, v);              check("after_fe_rsr", 32'(v), 32'(exp_rsr(1'b1)));
        bus_read(BASE + 16'd1, v);      check("after_fe_rbr", 32'(v), 32'(b));
        bus_write(BASE, 8'h00);
        bus_read(BASE, v);              check("fe_clr", 32'(v), 32'(exp_rsr(1'b1)));

        // ---- reset mid-frame (tx sending zeros, rx partway through a frame) ----
        rxd = 1'b0;
        bus_write(BASE + 16'd2, 8'h00);
        lows = 0;
        while (txd !== 1'b0 && lows < 200) begin
            @(negedge clock);
            lows++;
        end
        repeat (3 * BT) @(negedge clock);
        check("mid_tx_low", 32'(txd), 32'd0);
        reset = 1'b1;
        #1;
        check("rst_txd_immediate", 32'(txd), 32'd1);
        m_fi = 1'b0; m_oe = 1'b0; m_fe = 1'b0; m_rbr = 8'h00;
        repeat (2) @(negedge clock);
        rxd = 1'b1;
        reset = 1'b0;
        bus_read(BASE, v);              check("post_rst_rsr", 32'(v), 32'h20);
        bus_read(BASE + 16'd1, v);      check("post_rst_rbr", 32'(v), 32'h00);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (txd !== 1'b1) lows++;
        end
        check("post_rst_txd_idle", 32'(lows), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
